// File: rtl/if_fetch.sv
// if_fetch: instruction fetch stage with in-order pipelined imem requests and a small
// instruction buffer. Define FETCH_ALIGN_CHECK_EN to turn misaligned PCs into id_exc entries.
module if_fetch #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    INST_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [INST_WIDTH-1:0] imem_rdata,
  input  logic                  redirect_en,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  input  logic                  id_ready,
  output logic                  id_valid,
  output logic [ADDR_WIDTH-1:0] id_addr,
  output logic [INST_WIDTH-1:0] id_inst
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic                  id_exc
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {BOOT, RUN, DRAIN} state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [CW-1:0]         outst_q, outst_nxt, discard_q, buf_cnt;
  logic [PW-1:0]         aq_rd, aq_wr, buf_rd, buf_wr;
  logic [ADDR_WIDTH-1:0] aq_addr  [DEPTH];
  logic [ADDR_WIDTH-1:0] buf_addr [DEPTH];
  logic [INST_WIDTH-1:0] buf_inst [DEPTH];
  logic                  credit_ok, fetch_ok, issue, resp, keep, pop, push, exc_push;
  logic [ADDR_WIDTH-1:0] push_addr;
  logic [INST_WIDTH-1:0] push_inst;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Handshakes: a request transfers when imem_req && imem_gnt; a response is taken whenever
  // imem_rvalid is high with a fetch outstanding; an entry leaves when id_valid && id_ready.
  assign credit_ok = (int'(outst_q) + int'(buf_cnt)) < DEPTH;
  assign imem_req  = (state_q == RUN) && !redirect_en && credit_ok && fetch_ok;
  assign issue     = imem_req && imem_gnt;
  assign resp      = imem_rvalid && (outst_q != '0);
  assign keep      = resp && (discard_q == '0) && !redirect_en;
  assign pop       = id_valid && id_ready && !redirect_en;
  assign push      = keep || exc_push;
  assign outst_nxt = outst_q + CW'(issue) - CW'(resp);
  assign push_addr = keep ? aq_addr[aq_rd] : pc_q;
  assign push_inst = keep ? imem_rdata : '0;

  assign id_valid  = (buf_cnt != '0);
  assign id_addr   = id_valid ? buf_addr[buf_rd] : '0;
  assign id_inst   = id_valid ? buf_inst[buf_rd] : '0;

`ifdef FETCH_ALIGN_CHECK_EN
  logic halt_q;
  logic buf_exc [DEPTH];

  // A misaligned PC waits for the pipe to empty, then posts a single exception entry.
  assign fetch_ok  = (pc_q[1:0] == 2'b00);
  assign exc_push  = (state_q == RUN) && !redirect_en && !fetch_ok && !halt_q &&
                     (outst_q == '0) && (int'(buf_cnt) < DEPTH);
  assign imem_addr = pc_q;
  assign id_exc    = id_valid ? buf_exc[buf_rd] : 1'b0;

  always_ff @(posedge clk) begin
    if (push) buf_exc[buf_wr] <= exc_push;
  end
`else
  assign fetch_ok  = 1'b1;
  assign exc_push  = 1'b0;
  assign imem_addr = {pc_q[ADDR_WIDTH-1:2], 2'b00};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= BOOT;
      pc_q      <= RESET_PC;
      outst_q   <= '0;
      discard_q <= '0;
      aq_rd     <= '0;
      aq_wr     <= '0;
      buf_rd    <= '0;
      buf_wr    <= '0;
      buf_cnt   <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
      halt_q    <= 1'b0;
`endif
    end else begin
      outst_q <= outst_nxt;
      if (issue) aq_wr <= ptr_inc(aq_wr);
      if (resp)  aq_rd <= ptr_inc(aq_rd);
      if (redirect_en) begin
        // Every fetch still in flight after this edge belongs to the old path.
        pc_q      <= redirect_addr;
        discard_q <= outst_nxt;
        state_q   <= (outst_nxt != '0) ? DRAIN : RUN;
        buf_rd    <= '0;
        buf_wr    <= '0;
        buf_cnt   <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
        halt_q    <= 1'b0;
`endif
      end else begin
        if (issue) pc_q <= pc_q + ADDR_WIDTH'(4);
        if (resp && (discard_q != '0)) discard_q <= discard_q - 1'b1;
        case (state_q)
          BOOT:    state_q <= RUN;
          DRAIN:   if (resp && (discard_q == CW'(1))) state_q <= RUN;
          default: ;
        endcase
        if (push) buf_wr <= ptr_inc(buf_wr);
        if (pop)  buf_rd <= ptr_inc(buf_rd);
        buf_cnt <= buf_cnt + CW'(push) - CW'(pop);
`ifdef FETCH_ALIGN_CHECK_EN
        if (exc_push) halt_q <= 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (issue) aq_addr[aq_wr] <= pc_q;
    if (push) begin
      buf_addr[buf_wr] <= push_addr;
      buf_inst[buf_wr] <= push_inst;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: randomized fetch-stage bench with an in-bench memory and a queue-based
// model of in-flight fetches and buffered instructions, plus directed literal checks.
module tb_if_fetch;
  localparam int AW = 32;
  localparam int IW = 32;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          imem_req, imem_gnt, imem_rvalid, redirect_en, id_ready, id_valid;
  logic [AW-1:0] imem_addr, redirect_addr, id_addr;
  logic [IW-1:0] imem_rdata, id_inst;
  logic          w_req, w_gnt, w_rvalid, w_redir, w_ready, w_valid;
  logic [AW-1:0] w_addr, w_raddr, w_iaddr;
  logic [IW-1:0] w_rdata, w_inst;
`ifdef FETCH_ALIGN_CHECK_EN
  logic          id_exc, w_exc;
`endif

  always #5 clk = ~clk;

  if_fetch #(.ADDR_WIDTH(AW), .INST_WIDTH(IW), .RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .redirect_en(redirect_en),
    .redirect_addr(redirect_addr), .id_ready(id_ready), .id_valid(id_valid),
    .id_addr(id_addr), .id_inst(id_inst)
`ifdef FETCH_ALIGN_CHECK_EN
    , .id_exc(id_exc)
`endif
  );

  if_fetch #(.ADDR_WIDTH(AW), .INST_WIDTH(IW), .RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) dut_w (
    .clk(clk), .rst(rst), .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(w_gnt),
    .imem_rvalid(w_rvalid), .imem_rdata(w_rdata), .redirect_en(w_redir),
    .redirect_addr(w_raddr), .id_ready(w_ready), .id_valid(w_valid),
    .id_addr(w_iaddr), .id_inst(w_inst)
`ifdef FETCH_ALIGN_CHECK_EN
    , .id_exc(w_exc)
`endif
  );

  typedef struct {
    logic [AW-1:0] addr;
    int            due;
    bit            stale;
  } fl_t;

  int            n_checks = 0;
  int            n_errors = 0;
  int            cyc = 0;
  fl_t           inflight[$];
  logic [63:0]   exp_q[$];
  logic [AW-1:0] m_pc;
  bit            m_boot;
  bit            exp_req;

  bit            gnt_always, spurious_en, redir_next;
  int            lat_min, lat_max, ready_mode;
  logic [AW-1:0] redir_addr_next;

  logic [AW-1:0] gnt_log[$], del_log[$], w_log[$];
  int            gnt_cyc[$], del_cyc[$];
  int            first_valid_cyc, w_out;
  logic          s_req, s_valid, s_rvalid;
  logic [AW-1:0] s_addr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    redirect_en = 1'b0; redirect_addr = '0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    imem_rdata = '0; id_ready = 1'b0;
    w_gnt = 1'b0; w_rvalid = 1'b0; w_rdata = '0; w_redir = 1'b0; w_raddr = '0; w_ready = 1'b0;
    #1;
    check("rst_imem_req", imem_req, 0);
    check("rst_id_valid", id_valid, 0);
    check("rst_id_addr", id_addr, 0);
    check("rst_id_inst", id_inst, 0);
    inflight.delete(); exp_q.delete();
    gnt_log.delete(); gnt_cyc.delete(); del_log.delete(); del_cyc.delete(); w_log.delete();
    m_pc = 32'h0; m_boot = 1'b1; cyc = 0; first_valid_cyc = -1; w_out = 0; redir_next = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  // One clock: drive inputs, compare DUT against the model, then advance the model.
  task automatic step();
    bit          any_stale, do_resp, do_gnt;
    fl_t         head, e;
    logic [63:0] hd;
    @(negedge clk);
    redirect_en = redir_next;
    redirect_addr = redir_addr_next;
    redir_next = 1'b0;
    case (ready_mode)
      0:       id_ready = 1'b0;
      1:       id_ready = 1'b1;
      default: id_ready = ($urandom_range(0, 3) != 0);
    endcase
    imem_gnt = gnt_always ? 1'b1 : ($urandom_range(0, 2) != 0);
    imem_rdata = $urandom();
    if (inflight.size() > 0) imem_rvalid = (inflight[0].due <= cyc);
    else imem_rvalid = spurious_en && ($urandom_range(0, 15) == 0);
    w_gnt = 1'b1; w_ready = 1'b1; w_rvalid = (w_out > 0); w_rdata = $urandom();
    #1;

    any_stale = 1'b0;
    foreach (inflight[i]) if (inflight[i].stale) any_stale = 1'b1;
    exp_req = !m_boot && !redirect_en && !any_stale && ((inflight.size() + exp_q.size()) < DEPTH);
    check("imem_req", imem_req, exp_req);
    if (exp_req) check("imem_addr", imem_addr, {m_pc[AW-1:2], 2'b00});
    check("id_valid", id_valid, (exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      hd = exp_q[0];
      check("id_addr", id_addr, hd[63:32]);
      check("id_inst", id_inst, hd[31:0]);
    end else begin
      check("id_addr_idle", id_addr, 0);
      check("id_inst_idle", id_inst, 0);
    end

    s_req = imem_req; s_addr = imem_addr; s_valid = id_valid; s_rvalid = imem_rvalid;
    if (imem_req && imem_gnt) begin gnt_log.push_back(imem_addr); gnt_cyc.push_back(cyc); end
    if (id_valid && id_ready && !redirect_en) begin del_log.push_back(id_addr); del_cyc.push_back(cyc); end
    if (id_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (w_req && w_gnt) begin w_log.push_back(w_addr); w_out++; end
    if (w_rvalid) w_out--;

    do_resp = imem_rvalid && (inflight.size() > 0);
    do_gnt = exp_req && imem_gnt;
    if (do_resp) head = inflight.pop_front();
    if (redirect_en) begin
      foreach (inflight[i]) inflight[i].stale = 1'b1;
      exp_q.delete();
      m_pc = redirect_addr;
    end else begin
      if (exp_q.size() > 0 && id_ready) void'(exp_q.pop_front());
      if (do_resp && !head.stale) exp_q.push_back({head.addr, imem_rdata});
      if (do_gnt) begin
        e.addr = m_pc;
        e.due = cyc + $urandom_range(lat_min, lat_max);
        if (inflight.size() > 0 && e.due < inflight[$].due) e.due = inflight[$].due;
        e.stale = 1'b0;
        inflight.push_back(e);
        m_pc = m_pc + 32'd4;
      end
    end
    m_boot = 1'b0;
    cyc++;
  endtask

  initial begin
    int mark;
    logic [AW-1:0] ra;

    // Streaming at full grant rate, latency 1, no backpressure.
    gnt_always = 1'b1; lat_min = 1; lat_max = 1; ready_mode = 1; spurious_en = 1'b0;
    do_reset();
    repeat (12) step();
    check("a_gnt_count", (gnt_log.size() >= 3), 1);
    check("a_gnt0", gnt_log[0], 32'h0);
    check("a_gnt1", gnt_log[1], 32'h4);
    check("a_gnt2", gnt_log[2], 32'h8);
    check("a_first_gnt_cyc", gnt_cyc[0], 1);
    check("a_first_valid_cyc", first_valid_cyc, 3);
    check("a_del_count", (del_log.size() >= 3), 1);
    check("a_del0", del_log[0], 32'h0);
    check("a_del1", del_log[1], 32'h4);
    check("a_del2", del_log[2], 32'h8);
    check("wrap_count", (w_log.size() >= 3), 1);
    check("wrap0", w_log[0], 32'hFFFF_FFF8);
    check("wrap1", w_log[1], 32'hFFFF_FFFC);
    check("wrap2", w_log[2], 32'h0000_0000);

    // Decode stalled for 10 cycles, then released.
    do_reset();
    ready_mode = 0;
    repeat (10) step();
    check("b_stall_grants", gnt_log.size(), 2);
    check("b_req_stalled", s_req, 0);
    ready_mode = 1;
    repeat (6) step();
    check("b_del_count", (del_log.size() >= 2), 1);
    check("b_del0", del_log[0], 32'h0);
    check("b_del1", del_log[1], 32'h4);
    check("b_gapless", del_cyc[1] - del_cyc[0], 1);
    check("b_resume", gnt_log[2], 32'h8);

    // Latency 3 with two fetches in flight, then redirect.
    do_reset();
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 20 && inflight.size() < 2; i++) step();
    mark = del_log.size();
    redir_next = 1'b1; redir_addr_next = 32'h100;
    repeat (12) step();
    check("c_del_after", (del_log.size() > mark), 1);
    check("c_first_new", del_log[mark], 32'h100);
    check("c_first_new_gnt", gnt_log[2], 32'h100);

    // Redirect coinciding with a response and a consume.
    do_reset();
    lat_min = 1; lat_max = 1;
    repeat (3) step();
    redir_next = 1'b1; redir_addr_next = 32'h40;
    step();
    check("d_rvalid_same", s_rvalid, 1);
    check("d_pop_same", s_valid, 1);
    step();
    check("d_empty_after", s_valid, 0);
    check("d_req_after", s_req, 1);
    check("d_addr_after", s_addr, 32'h40);

    // Random traffic: grants, latency, backpressure, redirects, stray responses.
    do_reset();
    gnt_always = 1'b0; lat_min = 1; lat_max = 4; spurious_en = 1'b1;
    redir_next = 1'b1; redir_addr_next = 32'h3000;
    for (int i = 0; i < 3000; i++) begin
      ready_mode = ((i % 500) >= 250 && (i % 500) < 270) ? 0 : 2;
      if (!redir_next && $urandom_range(0, 24) == 0) begin
        case ($urandom_range(0, 3))
          0:       ra = $urandom() & 32'hFFFF_FFFC;
          1:       ra = 32'hFFFF_FFF8;
          2:       ra = $urandom();
          default: ra = 32'h100;
        endcase
        redir_next = 1'b1; redir_addr_next = ra;
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
